// File: rtl/ws2812b_rx_if.sv
// WS2812B receiver bus: the serial line into the decoder and everything it reports back.
// The master side drives the line (transmitter or bench); the slave side is the decoder.
interface ws2812b_rx_if;
    logic        dataIn;
    logic [23:0] pixel;
    logic        pixelValid;
    logic [7:0]  pixelIndex;
    logic        frameDone;
    logic [7:0]  frameLen;
    logic        bitError;
    logic        synced;

    modport master (
        output dataIn,
        input  pixel,
        input  pixelValid,
        input  pixelIndex,
        input  frameDone,
        input  frameLen,
        input  bitError,
        input  synced
    );

    modport slave (
        input  dataIn,
        output pixel,
        output pixelValid,
        output pixelIndex,
        output frameDone,
        output frameLen,
        output bitError,
        output synced
    );
endinterface

// File: rtl/ws2812b_rx.sv
// WS2812B NRZ receive decoder.
// Synchronises the serial line, measures each high pulse, classifies it as a 0 or 1,
// assembles 24-bit GRB words MSB first and detects the long low latch that ends a frame.
// After reset or a protocol error the decoder stays deaf until a full latch-length low
// period has been seen, so it never starts decoding in the middle of a word.
module ws2812b_rx #(
    parameter int MIN_HIGH   = 5,
    parameter int BIT_THRESH = 30,
    parameter int MAX_HIGH   = 60,
    parameter int RESET_LOW  = 14000,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         reset,
    ws2812b_rx_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0] MAXHI_C  = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] LATCH_C  = CNT_W'(RESET_LOW);
    localparam logic [4:0]       LAST_BIT = 5'd23;

    // Input path
    logic [1:0] sync_reg;
    logic       sp_reg;
    logic       s;
    logic       rise;
    logic       fall;

    // Pulse-width measurement
    logic [CNT_W-1:0] hi_cnt_reg;
    logic [CNT_W-1:0] hi_cnt_next;
    logic [CNT_W-1:0] lo_cnt_reg;
    logic [CNT_W-1:0] lo_cnt_next;
    logic             latch_hit;
    logic             is_glitch;
    logic             too_long;
    logic             bit_val;

    // Word assembly and frame bookkeeping
    state_t      state_reg;
    logic [23:0] shift_reg;
    logic [23:0] shift_next;
    logic [4:0]  bit_cnt_reg;
    logic [7:0]  pix_cnt_reg;
    logic [7:0]  pix_cnt_inc;

    // Registered outputs
    logic [23:0] pixel_reg;
    logic        pixel_valid_reg;
    logic [7:0]  pixel_index_reg;
    logic        frame_done_reg;
    logic [7:0]  frame_len_reg;
    logic        bit_error_reg;
    logic        synced_reg;

    assign s    = sync_reg[1];
    assign rise = s & ~sp_reg;
    assign fall = ~s & sp_reg;

    // Two-flop synchroniser for the asynchronous line plus a delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= 2'b00;
            sp_reg   <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], bus.dataIn};
            sp_reg   <= s;
        end
    end

    // Next values of the saturating high/low width counters; each restarts at 1 on its own edge
    always_comb begin
        hi_cnt_next = hi_cnt_reg;
        lo_cnt_next = lo_cnt_reg;
        if (s) begin
            if (rise) begin
                hi_cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (hi_cnt_reg != CNT_MAX) begin
                hi_cnt_next = hi_cnt_reg + 1'b1;
            end
        end else begin
            if (fall) begin
                lo_cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (lo_cnt_reg != CNT_MAX) begin
                lo_cnt_next = lo_cnt_reg + 1'b1;
            end
        end
    end

    // Width counters
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_cnt_reg <= '0;
            lo_cnt_reg <= '0;
        end else begin
            hi_cnt_reg <= hi_cnt_next;
            lo_cnt_reg <= lo_cnt_next;
        end
    end

    // Pulse classification and the single-cycle latch event
    always_comb begin
        // The latch fires only on the cycle the low count steps onto RESET_LOW,
        // so one long low period produces exactly one event.
        latch_hit   = ~s && (lo_cnt_next == LATCH_C) && (lo_cnt_reg != LATCH_C);
        is_glitch   = (hi_cnt_reg < MIN_C);
        too_long    = (hi_cnt_reg > MAXHI_C);
        bit_val     = (hi_cnt_reg >= THRESH_C);
        shift_next  = {shift_reg[22:0], bit_val};
        pix_cnt_inc = (pix_cnt_reg == 8'hFF) ? 8'hFF : pix_cnt_reg + 8'd1;
    end

    // Decoder state machine with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_SYNC;
            shift_reg       <= '0;
            bit_cnt_reg     <= '0;
            pix_cnt_reg     <= '0;
            pixel_reg       <= '0;
            pixel_valid_reg <= 1'b0;
            pixel_index_reg <= '0;
            frame_done_reg  <= 1'b0;
            frame_len_reg   <= '0;
            bit_error_reg   <= 1'b0;
            synced_reg      <= 1'b0;
        end else begin
            pixel_valid_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            bit_error_reg   <= 1'b0;

            case (state_reg)
                ST_SYNC: begin
                    // Silent start: wait for a full latch period before trusting the line
                    if (latch_hit) begin
                        state_reg   <= ST_IDLE;
                        synced_reg  <= 1'b1;
                        shift_reg   <= '0;
                        bit_cnt_reg <= '0;
                        pix_cnt_reg <= '0;
                    end
                end

                ST_IDLE: begin
                    if (rise) begin
                        state_reg <= ST_HIGH;
                    end else if (latch_hit) begin
                        // A partial word in the shift register is dropped here
                        frame_done_reg <= 1'b1;
                        frame_len_reg  <= pix_cnt_reg;
                        pix_cnt_reg    <= '0;
                        bit_cnt_reg    <= '0;
                        shift_reg      <= '0;
                    end
                end

                ST_HIGH: begin
                    if (too_long) begin
                        // Over-long high: abandon the partial word and resynchronise
                        bit_error_reg <= 1'b1;
                        synced_reg    <= 1'b0;
                        bit_cnt_reg   <= '0;
                        shift_reg     <= '0;
                        state_reg     <= ST_ERR;
                    end else if (fall) begin
                        state_reg <= ST_IDLE;
                        if (!is_glitch) begin
                            if (bit_cnt_reg == LAST_BIT) begin
                                pixel_reg       <= shift_next;
                                pixel_valid_reg <= 1'b1;
                                pixel_index_reg <= pix_cnt_reg;
                                pix_cnt_reg     <= pix_cnt_inc;
                                bit_cnt_reg     <= '0;
                                shift_reg       <= '0;
                            end else begin
                                shift_reg   <= shift_next;
                                bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            end
                        end
                    end
                end

                ST_ERR: begin
                    // Recovery needs a full latch period; the aborted frame is not reported
                    if (latch_hit) begin
                        state_reg   <= ST_IDLE;
                        synced_reg  <= 1'b1;
                        pix_cnt_reg <= '0;
                        bit_cnt_reg <= '0;
                        shift_reg   <= '0;
                    end
                end

                default: begin
                    state_reg  <= ST_SYNC;
                    synced_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pixel      = pixel_reg;
    assign bus.pixelValid = pixel_valid_reg;
    assign bus.pixelIndex = pixel_index_reg;
    assign bus.frameDone  = frame_done_reg;
    assign bus.frameLen   = frame_len_reg;
    assign bus.bitError   = bit_error_reg;
    assign bus.synced     = synced_reg;

endmodule

// File: tb/tb_ws2812b_rx.sv
// Directed bench for ws2812b_rx: drives NRZ pulse trains on the serial line and checks
// decoded words, frame latches, glitch rejection, error recovery and mid-frame reset.
// The latch period is shortened to keep the run short; all other timing is nominal.
module tb_ws2812b_rx;

    localparam int RESET_LOW = 1400;
    localparam int LATCH_CYC = RESET_LOW + 1000;

    logic clk = 1'b0;
    logic reset;

    ws2812b_rx_if bus ();

    ws2812b_rx #(
        .MIN_HIGH   (5),
        .BIT_THRESH (30),
        .MAX_HIGH   (60),
        .RESET_LOW  (RESET_LOW),
        .CNT_W      (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log written only by the monitor
    logic [23:0] pv_pix_q [$];
    logic [7:0]  pv_idx_q [$];
    int          pv_cyc_q [$];
    int          fd_count = 0;
    logic [7:0]  fd_len_last = 8'd0;
    int          be_count = 0;

    always @(negedge clk) begin
        if (bus.pixelValid) begin
            pv_pix_q.push_back(bus.pixel);
            pv_idx_q.push_back(bus.pixelIndex);
            pv_cyc_q.push_back(cyc);
            $display("pixel %06h index %0d at cycle %0d", bus.pixel, bus.pixelIndex, cyc);
        end
        if (bus.frameDone) begin
            fd_count++;
            fd_len_last = bus.frameLen;
            $display("frame done len %0d at cycle %0d", bus.frameLen, cyc);
        end
        if (bus.bitError) begin
            be_count++;
            $display("bit error at cycle %0d", cyc);
        end
    end

    int checks = 0;
    int errors = 0;
    int last_fall_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Assumes the caller is positioned just after a falling clock edge
    task automatic send_pulse(input int hi, input int lo);
        bus.dataIn = 1'b1;
        repeat (hi) @(negedge clk);
        bus.dataIn = 1'b0;
        last_fall_cyc = cyc;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] value, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            if (value[i]) send_pulse(40, 22);
            else          send_pulse(20, 42);
        end
    endtask

    task automatic latch_low();
        bus.dataIn = 1'b0;
        repeat (LATCH_CYC) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pixel"},      bus.pixel,      32'h0);
        check({tag, "_pixelValid"}, bus.pixelValid, 32'h0);
        check({tag, "_pixelIndex"}, bus.pixelIndex, 32'h0);
        check({tag, "_frameDone"},  bus.frameDone,  32'h0);
        check({tag, "_frameLen"},   bus.frameLen,   32'h0);
        check({tag, "_bitError"},   bus.bitError,   32'h0);
        check({tag, "_synced"},     bus.synced,     32'h0);
    endtask

    logic [23:0] w3 [5] = '{24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hFFFFFF, 24'h000000};

    initial begin
        int pv_base;
        int fd_base;
        int be_base;
        int t_ref;

        // Reset
        reset      = 1'b1;
        bus.dataIn = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // 1: resync after reset
        pv_base = pv_pix_q.size();
        fd_base = fd_count;
        for (int i = 0; i < 3; i++) send_pulse(40, 45);
        t_ref = last_fall_cyc;
        while (cyc < t_ref + RESET_LOW - 10) @(negedge clk);
        check("t1_synced_before", bus.synced, 32'h0);
        while (cyc < t_ref + RESET_LOW + 20) @(negedge clk);
        check("t1_synced_after", bus.synced, 32'h1);
        latch_low();
        check("t1_no_pixel", pv_pix_q.size() - pv_base, 32'd0);
        check("t1_no_frame", fd_count - fd_base, 32'd0);

        // 2: single pixel
        pv_base = pv_pix_q.size();
        fd_base = fd_count;
        send_bits(32'h123456, 24);
        check("t2_pv_count", pv_pix_q.size() - pv_base, 32'd1);
        check("t2_pixel", pv_pix_q[pv_base], 32'h123456);
        check("t2_index", pv_idx_q[pv_base], 32'd0);
        check("t2_latency", pv_cyc_q[pv_base] - last_fall_cyc, 32'd3);
        latch_low();
        check("t2_fd_count", fd_count - fd_base, 32'd1);
        check("t2_frame_len", fd_len_last, 32'd1);
        check("t2_frame_len_held", bus.frameLen, 32'd1);

        // 3: five-LED frame
        pv_base = pv_pix_q.size();
        fd_base = fd_count;
        for (int i = 0; i < 5; i++) send_bits({8'h00, w3[i]}, 24);
        check("t3_pv_count", pv_pix_q.size() - pv_base, 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_pixel%0d", i), pv_pix_q[pv_base + i], {8'h00, w3[i]});
            check($sformatf("t3_index%0d", i), pv_idx_q[pv_base + i], i);
        end
        latch_low();
        check("t3_fd_count", fd_count - fd_base, 32'd1);
        check("t3_frame_len", fd_len_last, 32'd5);

        // 4: glitch between bits, then a 12-bit partial word
        pv_base = pv_pix_q.size();
        fd_base = fd_count;
        be_base = be_count;
        send_bits(32'hA5A, 12);
        send_pulse(3, 10);
        send_bits(32'h5A5, 12);
        send_bits(32'hFFF, 12);
        check("t4_pv_count", pv_pix_q.size() - pv_base, 32'd1);
        check("t4_pixel", pv_pix_q[pv_base], 32'hA5A5A5);
        check("t4_index_restart", pv_idx_q[pv_base], 32'd0);
        latch_low();
        check("t4_no_error", be_count - be_base, 32'd0);
        check("t4_fd_count", fd_count - fd_base, 32'd1);
        check("t4_frame_len", fd_len_last, 32'd1);
        check("t4_pixel_held", bus.pixel, 32'hA5A5A5);

        // 5: over-long high mid-word, recovery after a latch period
        pv_base = pv_pix_q.size();
        fd_base = fd_count;
        be_base = be_count;
        send_bits(32'h3FF, 10);
        send_pulse(70, 20);
        check("t5_error_pulse", be_count - be_base, 32'd1);
        check("t5_synced_drop", bus.synced, 32'h0);
        send_bits(32'hC0FFEE, 24);
        check("t5_bits_ignored", pv_pix_q.size() - pv_base, 32'd0);
        latch_low();
        check("t5_no_frame", fd_count - fd_base, 32'd0);
        check("t5_synced_back", bus.synced, 32'h1);
        check("t5_error_once", be_count - be_base, 32'd1);
        send_bits(32'h5A5A5A, 24);
        check("t5_resume_count", pv_pix_q.size() - pv_base, 32'd1);
        check("t5_resume_pixel", pv_pix_q[pv_base], 32'h5A5A5A);
        check("t5_resume_index", pv_idx_q[pv_base], 32'd0);

        // 6: reset after 30 bits
        pv_base = pv_pix_q.size();
        send_bits(32'h111111, 24);
        send_bits(32'h2A, 6);
        check("t6_pv_count", pv_pix_q.size() - pv_base, 32'd1);
        check("t6_index", bus.pixelIndex, 32'd1);
        check("t6_pixel", bus.pixel, 32'h111111);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("t6_reset");
        reset = 1'b0;
        pv_base = pv_pix_q.size();
        fd_base = fd_count;
        send_bits(32'h222222, 24);
        check("t6_ignored_before_sync", pv_pix_q.size() - pv_base, 32'd0);
        latch_low();
        check("t6_synced", bus.synced, 32'h1);
        check("t6_no_frame_on_sync", fd_count - fd_base, 32'd0);
        send_bits(32'h333333, 24);
        latch_low();
        check("t6_new_count", pv_pix_q.size() - pv_base, 32'd1);
        check("t6_new_pixel", pv_pix_q[pv_base], 32'h333333);
        check("t6_new_index", pv_idx_q[pv_base], 32'd0);
        check("t6_fd_count", fd_count - fd_base, 32'd1);
        check("t6_frame_len", fd_len_last, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
